product_bcd_converter: RTL
==========================

Name: product_bcd_converter

Overview:
Downstream stage of the 8-bit signed multiplier. It consumes the 16-bit two's-complement product {A register, B register} once multiplication finishes. A sequential double-dabble engine converts it to a sign flag plus five BCD digits for decimal display on the hex displays. The engine processes one product bit per clock and uses a simple Start/Busy/Done handshake.

Parameters:
WIDTH, 16, product width in bits (two's complement)
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  request conversion; level-sampled only in IDLE
Product  input  WIDTH  signed product, {Aval,Bval}
Busy  output  1  conversion in progress
Done  output  1  one-cycle pulse; Digits/Neg updated in the same cycle
Valid  output  1  Digits/Neg hold a completed result
Neg  output  1  result is negative
Digits  output  4*DIGITS  BCD; nibble 0 = ones, nibble DIGITS-1 = most significant

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Busy=0, Done=0, Valid=0, Neg=0, Digits=0; working registers and counter cleared. This applies at any time, including mid-conversion. No partial result survives.
- States: IDLE, SHIFT, DONE.
- IDLE, Start=1 at edge E:
  - Capture magnitude: Product if Product[WIDTH-1]=0, else the two's complement of Product, computed WIDTH+1 bits wide so 0x8000 gives 32768.
  - Capture sign into a working sign register.
  - Clear the BCD accumulator; load counter=WIDTH; go to SHIFT; Valid←0.
- SHIFT, each edge:
  - For every BCD nibble >= 5, add 3 (combinational adjust).
  - Shift {BCD accumulator, magnitude} left by 1.
  - Decrement counter.
  - When counter transitions 1→0 (edge E+16 for WIDTH=16): load Digits from the adjusted/shifted accumulator, load Neg from the working sign, go to DONE.
- DONE: Done=1, Valid=1 (registered outputs, visible after edge E+16). Next edge goes to IDLE with Done=0 and Valid held at 1.
- Busy=1 exactly while the state is SHIFT (from after E to E+16). Total latency is WIDTH+1 edges from the Start sample to Done.
- Start while in SHIFT or DONE is ignored; the Product change is not sampled.
- Start held high continuously causes back-to-back conversions, one every WIDTH+2 edges. Each re-samples Product in IDLE.
- Neg for zero is always 0. Product=0x8000 gives Neg=1, Digits=32768.
- Digits and Neg keep the previous result during a new conversion; Valid=0 marks them stale.
- No arithmetic overflow is possible with the parameter constraint. The BCD accumulator is exactly 4*DIGITS bits; bits shifted out of the top are discarded by design and are always zero.
- Counter width is $clog2(WIDTH+1).

Decomposition:
- Package bcd_pkg:
  - state typedef enum {IDLE, SHIFT, DONE}
  - localparam defaults WIDTH=16, DIGITS=5
  - BCD_ADJ_THRESHOLD=5, BCD_ADJ_ADD=3
- Sub-module bcd_adjust: combinational 4-bit "if >=5 add 3". Instantiate it DIGITS times as an array.
- Top: FSM, counter, magnitude/sign capture, output registers.

Test Plan:
1. Reset, then Product=0x0000 with a 1-cycle Start → Busy for 16 cycles; Done pulse 17 edges after the Start sample; Digits=0x00000, Neg=0, Valid=1.
2. Product=0x3F01 (127*127) → Digits=0x16129, Neg=0. Then Product=0x4000 (-128*-128) → Digits=0x16384, Neg=0.
3. Product=0xFFFF → Neg=1, Digits=0x00001. Product=0xC080 (-128*127) → Neg=1, Digits=0x16256. Product=0x8000 → Neg=1, Digits=0x32768.
4. Start with 0x0064 (100); pulse Start again with Product=0x0001 at cycle 5 of SHIFT → second request ignored; result Digits=0x00100; exactly one Done pulse.
5. Reset asserted asynchronously at cycle 8 of SHIFT (between clock edges) → all outputs 0 immediately; after release, Busy stays 0 until a new Start.
6. Start held high with Product=0x0309 (777) → periodic Done every 18 edges, each with Digits=0x00777. Valid drops to 0 during each SHIFT phase and returns to 1 with each Done.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the signed-product to BCD converter.
package bcd_pkg;
   localparam int DEFAULT_WIDTH     = 16;
   localparam int DEFAULT_DIGITS    = 5;
   localparam int BCD_ADJ_THRESHOLD = 5;
   localparam int BCD_ADJ_ADD       = 3;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);
   always_comb begin
      dout = din;
      if (din >= 4'(BCD_ADJ_THRESHOLD)) dout = din + 4'(BCD_ADJ_ADD);
   end
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble conversion of a signed product into sign + BCD digits,
// one product bit per clock, with a Start/Busy/Done handshake.
module product_bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DIGITS = DEFAULT_DIGITS
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Product,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Valid,
   output logic                  Neg,
   output logic [4*DIGITS-1:0]   Digits
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
   logic             sign_q, sign_d;
   logic [BW-1:0]    digits_q, digits_d;
   logic             neg_q, neg_d;
   logic             valid_q, valid_d;

   bcd_adjust u_adj [DIGITS-1:0] (
      .din  (bcd_q),
      .dout (bcd_adj)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mag_d    = mag_q;
      bcd_d    = bcd_q;
      sign_d   = sign_q;
      digits_d = digits_q;
      neg_d    = neg_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               // Negating the most negative value wraps back to itself, which read
               // unsigned is exactly its magnitude, so WIDTH bits are enough.
               mag_d   = Product[WIDTH-1] ? (~Product + WIDTH'(1)) : Product;
               sign_d  = Product[WIDTH-1];
               bcd_d   = '0;
               cnt_d   = CW'(WIDTH);
               valid_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               digits_d = bcd_d;
               neg_d    = sign_q;
               valid_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mag_q    <= '0;
         bcd_q    <= '0;
         sign_q   <= 1'b0;
         digits_q <= '0;
         neg_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mag_q    <= mag_d;
         bcd_q    <= bcd_d;
         sign_q   <= sign_d;
         digits_q <= digits_d;
         neg_q    <= neg_d;
         valid_q  <= valid_d;
      end
   end

   assign Busy   = (state_q == SHIFT);
   assign Done   = (state_q == DONE);
   assign Valid  = valid_q;
   assign Neg    = neg_q;
   assign Digits = digits_q;
endmodule
